muskbus_arbiter: RTL

MUSKBUS_ARBITER -- requirements
Module: muskbus_arbiter

---
 rtl/muskbus_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/muskbus_arbiter.sv
// Round-robin arbiter multiplexing NCLIENTS masters onto one Muskbus top port.
// Optional ownership watchdog: define MUSKBUS_ARB_TIMEOUT_EN.
module muskbus_arbiter #(
    parameter int NCLIENTS = 2,
    parameter int TAG_W    = 13,
    parameter int TIMEOUT  = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NCLIENTS-1:0]       cl_bid,
    input  logic [NCLIENTS-1:0]       cl_reqcyc,
    input  logic [NCLIENTS*64-1:0]    cl_req,
    input  logic [NCLIENTS*TAG_W-1:0] cl_reqtag,
    output logic [NCLIENTS-1:0]       cl_gnt,
    output logic [NCLIENTS-1:0]       cl_reqack,
    output logic [NCLIENTS-1:0]       cl_respcyc,
    output logic [63:0]               cl_resp,
    input  logic [NCLIENTS-1:0]       cl_respack,
    output logic                      bus_bid,
    output logic                      bus_reqcyc,
    output logic [63:0]               bus_req,
    output logic [TAG_W-1:0]          bus_reqtag,
    output logic                      bus_respack,
    input  logic                      bus_grant,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [63:0]               bus_resp,
    output logic                      arb_err
);

    localparam int OW = (NCLIENTS > 1) ? $clog2(NCLIENTS) : 1;

    if (NCLIENTS < 2 || NCLIENTS > 8 || TIMEOUT < 1) begin : g_param_check
        $error("muskbus_arbiter: bad parameters");
    end

    typedef enum logic [1:0] {IDLE, ARB, OWNED} state_t;

    state_t        state, state_nxt;
    logic [OW-1:0] owner, owner_nxt;
    logic [OW-1:0] rr_ptr, rr_nxt;
    logic [OW-1:0] winner, owner_inc;
    logic          found;
    logic          owner_bid;
    logic          timeout;
    int            oi;

    assign oi        = int'(owner);
    assign owner_bid = cl_bid[owner];
    assign owner_inc = (owner == OW'(NCLIENTS - 1)) ? '0 : owner + 1'b1;
    assign cl_resp   = bus_resp;

    // First bidder at or above rr_ptr, wrapping around
    always_comb begin : winner_sel
        int k;
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NCLIENTS; i++) begin
            k = int'(rr_ptr) + i;
            if (k >= NCLIENTS) k = k - NCLIENTS;
            if (!found && cl_bid[k]) begin
                winner = OW'(k);
                found  = 1'b1;
            end
        end
    end

`ifdef MUSKBUS_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wdog;
    logic          err_q;
    logic          quiet;

    assign quiet   = !bus_reqack && !bus_respcyc;
    assign timeout = (state == OWNED) && quiet && (wdog == CW'(TIMEOUT - 1));
    assign arb_err = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wdog  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state != OWNED || !quiet || timeout) wdog <= '0;
            else                                    wdog <= wdog + 1'b1;
            if (timeout) err_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign arb_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
        unique case (state)
            IDLE: begin
                if (found) begin
                    owner_nxt = winner;
                    state_nxt = ARB;
                end
            end
            ARB: begin
                if (!owner_bid)     state_nxt = IDLE;
                else if (bus_grant) state_nxt = OWNED;
            end
            OWNED: begin
                if (!owner_bid || timeout) begin
                    state_nxt = IDLE;
                    rr_nxt    = owner_inc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Only the owner's lanes are forwarded; everything else idles at zero
    always_comb begin
        bus_bid     = 1'b0;
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;
        cl_gnt      = '0;
        cl_reqack   = '0;
        cl_respcyc  = '0;
        if (state == ARB) bus_bid = 1'b1;
        if (state == OWNED) begin
            bus_bid           = owner_bid;
            cl_gnt[owner]     = owner_bid;
            bus_reqcyc        = cl_reqcyc[owner];
            bus_req           = cl_req[64*oi +: 64];
            bus_reqtag        = cl_reqtag[TAG_W*oi +: TAG_W];
            bus_respack       = cl_respack[owner];
            cl_reqack[owner]  = bus_reqack;
            cl_respcyc[owner] = bus_respcyc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_nxt;
        end
    end

endmodule
